// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync, data enable, line/frame strobes and a frame counter.
// Optional run-time reprogrammable timing, applied at frame wrap, is enabled by VIDEO_TIMING_RUNTIME_CFG_EN.
module video_timing_gen #(
  parameter int CW          = 10,
  parameter int HRes        = 480,
  parameter int HFrontPorch = 2,
  parameter int HSyncPulse  = 41,
  parameter int HBackPorch  = 2,
  parameter int VRes        = 272,
  parameter int VFrontPorch = 2,
  parameter int VSyncPulse  = 10,
  parameter int VBackPorch  = 2,
  parameter int HSyncPol    = 0,
  parameter int VSyncPol    = 0,
  parameter int FW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_hres,
  input  logic [CW-1:0] cfg_hfp,
  input  logic [CW-1:0] cfg_hsp,
  input  logic [CW-1:0] cfg_hbp,
  input  logic [CW-1:0] cfg_vres,
  input  logic [CW-1:0] cfg_vfp,
  input  logic [CW-1:0] cfg_vsp,
  input  logic [CW-1:0] cfg_vbp,
  output logic          cfg_ready,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  typedef struct packed {
    logic [CW-1:0] hres, hfp, hsp, hbp;
    logic [CW-1:0] vres, vfp, vsp, vbp;
  } timing_t;

  localparam timing_t DefTiming = '{
    hres: CW'(HRes), hfp: CW'(HFrontPorch), hsp: CW'(HSyncPulse), hbp: CW'(HBackPorch),
    vres: CW'(VRes), vfp: CW'(VFrontPorch), vsp: CW'(VSyncPulse), vbp: CW'(VBackPorch)
  };
  localparam logic        HsOn = 1'(HSyncPol);
  localparam logic        VsOn = 1'(VSyncPol);
  localparam logic [CW:0] One  = (CW+1)'(1);

  timing_t       act;
  logic [CW-1:0] hc, vc;
  logic [CW:0]   hs_beg, hs_end, h_total;
  logic [CW:0]   vs_beg, vs_end, v_total;
  logic          h_last, v_last, frame_wrap;
  logic          h_sync_on, v_sync_on;
  logic          started;

  // One extra bit so a total of exactly 2**CW is representable.
  assign hs_beg  = {1'b0, act.hres} + {1'b0, act.hfp};
  assign hs_end  = hs_beg + {1'b0, act.hsp};
  assign h_total = hs_end + {1'b0, act.hbp};
  assign vs_beg  = {1'b0, act.vres} + {1'b0, act.vfp};
  assign vs_end  = vs_beg + {1'b0, act.vsp};
  assign v_total = vs_end + {1'b0, act.vbp};

  assign h_last     = ({1'b0, hc} == h_total - One);
  assign v_last     = ({1'b0, vc} == v_total - One);
  assign frame_wrap = h_last && v_last;
  assign h_sync_on  = ({1'b0, hc} >= hs_beg) && ({1'b0, hc} < hs_end);
  assign v_sync_on  = ({1'b0, vc} >= vs_beg) && ({1'b0, vc} < vs_end);

`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
  timing_t pend;

  // cfg_ready low means pend holds a timing set waiting for the next frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      act       <= DefTiming;
      pend      <= DefTiming;
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      pend      <= '{hres: cfg_hres, hfp: cfg_hfp, hsp: cfg_hsp, hbp: cfg_hbp,
                     vres: cfg_vres, vfp: cfg_vfp, vsp: cfg_vsp, vbp: cfg_vbp};
      cfg_ready <= 1'b0;
    end else if (en && frame_wrap && !cfg_ready) begin
      act       <= pend;
      cfg_ready <= 1'b1;
    end
  end
`else
  assign act = DefTiming;
`endif

  // NOTE: non-blocking assignments, so every register here samples the pre-edge hc/vc.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      hc <= h_last ? '0 : hc + CW'(1);
      if (h_last) vc <= v_last ? '0 : vc + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b0;
      hsync       <= ~HsOn;
      vsync       <= ~VsOn;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      started     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        sx          <= hc;
        sy          <= vc;
        de          <= (hc < act.hres) && (vc < act.vres);
        hsync       <= h_sync_on ? HsOn : ~HsOn;
        vsync       <= v_sync_on ? VsOn : ~VsOn;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
        // The first frame after reset is not a completed frame, so it is not counted.
        if ((hc == '0) && (vc == '0)) begin
          if (started) frame_cnt <= frame_cnt + FW'(1);
          started <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-geometry instance, an inverted-polarity twin and a default-geometry
// instance, all checked every cycle against a raster model plus hand-computed literal expectations.
module tb_video_timing_gen;

  typedef struct {
    int hres, hfp, hsp, hbp, vres, vfp, vsp, vbp;
  } geom_t;

  typedef struct {
    geom_t g, pend;
    bit    ready, started;
    int    mx, my;
    int    sx, sy, fc;
    bit    de, hs, vs, ls, fs;
  } mstate_t;

  geom_t g_small = '{8, 2, 3, 1, 5, 1, 2, 1};        // 14 x 9, frame 126 clks
  geom_t g_def   = '{480, 2, 41, 2, 272, 2, 10, 2};  // 525 x 286

  logic clk = 1'b0;
  logic rst, en, cfg_valid;
  logic [9:0] cfg_hres, cfg_hfp, cfg_hsp, cfg_hbp, cfg_vres, cfg_vfp, cfg_vsp, cfg_vbp;

  logic s_hs, s_vs, s_de, s_ls, s_fs, s_rdy;
  logic p_hs, p_vs, p_de, p_ls, p_fs, p_rdy;
  logic d_hs, d_vs, d_de, d_ls, d_fs, d_rdy;
  logic [9:0]  s_sx, s_sy, p_sx, p_sy, d_sx, d_sy;
  logic [2:0]  s_fc;
  logic [15:0] p_fc, d_fc;

  int vectors = 0;
  int fails   = 0;
  bit chk_on  = 1'b0;
  mstate_t m[3];

  always #5 clk = ~clk;

  video_timing_gen #(.HRes(8), .HFrontPorch(2), .HSyncPulse(3), .HBackPorch(1),
    .VRes(5), .VFrontPorch(1), .VSyncPulse(2), .VBackPorch(1), .FW(3)) dut_s (
    .clk(clk), .rst(rst), .en(en),
`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
    .cfg_valid(cfg_valid), .cfg_hres(cfg_hres), .cfg_hfp(cfg_hfp), .cfg_hsp(cfg_hsp),
    .cfg_hbp(cfg_hbp), .cfg_vres(cfg_vres), .cfg_vfp(cfg_vfp), .cfg_vsp(cfg_vsp),
    .cfg_vbp(cfg_vbp), .cfg_ready(s_rdy),
`endif
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .sx(s_sx), .sy(s_sy),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));

  video_timing_gen #(.HRes(8), .HFrontPorch(2), .HSyncPulse(3), .HBackPorch(1),
    .VRes(5), .VFrontPorch(1), .VSyncPulse(2), .VBackPorch(1),
    .HSyncPol(1), .VSyncPol(1)) dut_p (
    .clk(clk), .rst(rst), .en(en),
`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
    .cfg_valid(1'b0), .cfg_hres('0), .cfg_hfp('0), .cfg_hsp('0), .cfg_hbp('0),
    .cfg_vres('0), .cfg_vfp('0), .cfg_vsp('0), .cfg_vbp('0), .cfg_ready(p_rdy),
`endif
    .hsync(p_hs), .vsync(p_vs), .de(p_de), .sx(p_sx), .sy(p_sy),
    .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc));

  video_timing_gen dut_d (
    .clk(clk), .rst(rst), .en(en),
`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
    .cfg_valid(1'b0), .cfg_hres('0), .cfg_hfp('0), .cfg_hsp('0), .cfg_hbp('0),
    .cfg_vres('0), .cfg_vfp('0), .cfg_vsp('0), .cfg_vbp('0), .cfg_ready(d_rdy),
`endif
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .sx(d_sx), .sy(d_sy),
    .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Raster model: a pixel position walking the frame, outputs derived from the interval rules.
  function automatic mstate_t step(input mstate_t s, input geom_t def, input bit hpol, input bit vpol,
                                   input int fw, input bit r, input bit e, input bit cv, input geom_t cg);
    mstate_t n = s;
    bit wrap = 1'b0;
    int ht, vt;
    if (r) begin
      n.g = def; n.pend = def; n.ready = 1'b1; n.started = 1'b0;
      n.mx = 0; n.my = 0; n.sx = 0; n.sy = 0; n.fc = 0;
      n.de = 1'b0; n.hs = !hpol; n.vs = !vpol; n.ls = 1'b0; n.fs = 1'b0;
      return n;
    end
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (e) begin
      ht = s.g.hres + s.g.hfp + s.g.hsp + s.g.hbp;
      vt = s.g.vres + s.g.vfp + s.g.vsp + s.g.vbp;
      n.sx = s.mx;
      n.sy = s.my;
      n.de = (s.mx < s.g.hres) && (s.my < s.g.vres);
      n.hs = (s.mx >= s.g.hres + s.g.hfp && s.mx < s.g.hres + s.g.hfp + s.g.hsp) ? hpol : !hpol;
      n.vs = (s.my >= s.g.vres + s.g.vfp && s.my < s.g.vres + s.g.vfp + s.g.vsp) ? vpol : !vpol;
      n.ls = (s.mx == 0);
      n.fs = (s.mx == 0) && (s.my == 0);
      if (n.fs) begin
        if (s.started) n.fc = (s.fc + 1) % (1 << fw);
        n.started = 1'b1;
      end
      n.mx = (s.mx + 1) % ht;
      if (n.mx == 0) n.my = (s.my + 1) % vt;
      wrap = (n.mx == 0) && (n.my == 0);
    end
    if (cv && s.ready) begin
      n.pend  = cg;
      n.ready = 1'b0;
    end else if (wrap && !s.ready) begin
      n.g     = s.pend;
      n.ready = 1'b1;
    end
    return n;
  endfunction

  function automatic geom_t cur_cfg();
    return '{int'(cfg_hres), int'(cfg_hfp), int'(cfg_hsp), int'(cfg_hbp),
             int'(cfg_vres), int'(cfg_vfp), int'(cfg_vsp), int'(cfg_vbp)};
  endfunction

  always @(posedge clk) begin
    m[0] <= step(m[0], g_small, 1'b0, 1'b0, 3,  rst, en, cfg_valid, cur_cfg());
    m[1] <= step(m[1], g_small, 1'b1, 1'b1, 16, rst, en, 1'b0,      cur_cfg());
    m[2] <= step(m[2], g_def,   1'b0, 1'b0, 16, rst, en, 1'b0,      cur_cfg());
  end

  task automatic cmp(input int i, input string t, input int sx, input int sy, input bit de,
                     input bit hs, input bit vs, input bit ls, input bit fs, input int fc, input bit rdy);
    check({t, ".sx"}, sx, m[i].sx);
    check({t, ".sy"}, sy, m[i].sy);
    check({t, ".de"}, int'(de), int'(m[i].de));
    check({t, ".hsync"}, int'(hs), int'(m[i].hs));
    check({t, ".vsync"}, int'(vs), int'(m[i].vs));
    check({t, ".line_start"}, int'(ls), int'(m[i].ls));
    check({t, ".frame_start"}, int'(fs), int'(m[i].fs));
    check({t, ".frame_cnt"}, fc, m[i].fc);
`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
    check({t, ".cfg_ready"}, int'(rdy), int'(m[i].ready));
`endif
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, "small", int'(s_sx), int'(s_sy), s_de, s_hs, s_vs, s_ls, s_fs, int'(s_fc), s_rdy);
      cmp(1, "pol",   int'(p_sx), int'(p_sy), p_de, p_hs, p_vs, p_ls, p_fs, int'(p_fc), p_rdy);
      cmp(2, "dflt",  int'(d_sx), int'(d_sy), d_de, d_hs, d_vs, d_ls, d_fs, int'(d_fc), d_rdy);
    end
  end

  initial begin
    int de_n, hs_n, hs_first, hs_last, ls2, fs_prev, de_acc, vs_acc, k_hit;
    bit done, prev_fs, found;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    {cfg_hres, cfg_hfp, cfg_hsp, cfg_hbp, cfg_vres, cfg_vfp, cfg_vsp, cfg_vbp} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    check("reset_sx", int'(s_sx), 0);
    check("reset_de", int'(s_de), 0);
    check("reset_hsync_low_pol", int'(s_hs), 1);
    check("reset_vsync_low_pol", int'(s_vs), 1);
    check("reset_hsync_high_pol", int'(p_hs), 0);
    check("reset_frame_cnt", int'(d_fc), 0);

    // One full default line: de, hsync window and line period.
    rst = 1'b0; en = 1'b1;
    de_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls2 = -1;
    for (int k = 0; k < 530; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("first_frame_start", int'(s_fs), 1);
        check("first_line_start", int'(d_ls), 1);
        check("first_de", int'(d_de), 1);
      end
      if (k < 525) begin
        de_n += int'(d_de);
        if (!d_hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(d_sx);
          hs_last = int'(d_sx);
        end
      end
      if (k > 0 && d_ls && ls2 < 0) ls2 = k;
    end
    check("line_de_clks", de_n, 480);
    check("line_hsync_clks", hs_n, 41);
    check("hsync_first_sx", hs_first, 482);
    check("hsync_last_sx", hs_last, 522);
    check("line_period", ls2, 525);

    // Free run on the small raster, long enough for the 3-bit frame counter to wrap.
    fs_prev = -1; de_acc = 0; vs_acc = 0; done = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (s_fs) begin
        if (fs_prev >= 0 && !done) begin
          check("frame_period", k - fs_prev, 126);
          check("frame_de_clks", de_acc, 40);
          check("frame_vsync_clks", vs_acc, 28);
          done = 1'b1;
        end
        fs_prev = k; de_acc = 0; vs_acc = 0;
      end
      de_acc += int'(s_de);
      vs_acc += int'(!s_vs);
    end
    check("frame_period_seen", int'(done), 1);

    // en toggled every clock: half-rate raster, strobes still one clock wide.
    fs_prev = -1; done = 1'b0; prev_fs = 1'b0;
    for (int k = 0; k < 600; k++) begin
      en = (k % 2 == 0);
      @(negedge clk);
      if (s_fs) begin
        check("fs_one_clk_wide", int'(prev_fs), 0);
        if (fs_prev >= 0 && !done) begin
          check("frame_period_half_rate", k - fs_prev, 252);
          done = 1'b1;
        end
        fs_prev = k;
      end
      prev_fs = s_fs;
    end
    check("half_rate_period_seen", int'(done), 1);

    for (int k = 0; k < 300; k++) begin
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Mid-frame reset.
    en = 1'b1; found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (s_sx == 10'd5 && s_sy == 10'd3) found = 1'b1;
    end
    check("reached_5_3", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sx", int'(s_sx), 0);
    check("midrst_sy", int'(s_sy), 0);
    check("midrst_de", int'(s_de), 0);
    check("midrst_hsync", int'(s_hs), 1);
    check("midrst_line_start", int'(s_ls), 0);
    rst = 1'b0;
    k_hit = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_fs) begin
        check("post_rst_frame_cnt", int'(s_fc), k_hit);
        k_hit++;
      end
    end
    check("post_rst_frames", k_hit, 3);

`ifdef VIDEO_TIMING_RUNTIME_CFG_EN
    // Run-time reprogramming: old timing holds until the frame wrap.
    cfg_valid = 1'b1;
    cfg_hres = 10'd640; cfg_hfp = 10'd16; cfg_hsp = 10'd96; cfg_hbp = 10'd48;
    cfg_vres = 10'd480; cfg_vfp = 10'd10; cfg_vsp = 10'd2;  cfg_vbp = 10'd33;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_ready_after_write", int'(s_rdy), 0);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (s_fs) found = 1'b1;
    end
    check("cfg_wrap_seen", int'(found), 1);
    check("cfg_ready_at_wrap", int'(s_rdy), 1);
    ls2 = -1;
    for (int k = 1; k < 1000 && ls2 < 0; k++) begin
      @(negedge clk);
      if (s_ls) ls2 = k;
    end
    check("new_line_period", ls2, 800);
`endif

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
